// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: Mealy stall/flush sequencer (RUN/DWAIT/HALTED), controls valid in the same cycle as their cause.
// Data-memory busy holds PC..EX/MEM and bubbles MEM/WB until dmem_Done; stall counter present with PIPE_STALL_CNT_EN.
module pipe_stall_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dec_ReadReg1,
    input  logic [2:0] dec_ReadReg2,
    input  logic       dec_Uses1,
    input  logic       dec_Uses2,
    input  logic       dec_Halt,
    input  logic [2:0] exe_WriteReg,
    input  logic       exe_RegWrite,
    input  logic       exe_DMemRead,
    input  logic       exe_BrTaken,
    input  logic       mem_DMemEn,
    input  logic       dmem_Stall,
    input  logic       dmem_Done,
    output logic       pc_Hold,
    output logic       ifid_Hold,
    output logic       idex_Hold,
    output logic       exmem_Hold,
    output logic       ifid_Flush,
    output logic       idex_Bubble,
    output logic       memwb_Bubble,
    output logic       halted
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DWAIT  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_dstall;
    logic   w_loaduse;

    // Done in the same cycle as Stall means the access has completed: no stall.
    assign w_dstall  = mem_DMemEn & dmem_Stall & ~dmem_Done;
    assign w_loaduse = exe_DMemRead & exe_RegWrite &
                       ((dec_Uses1 & (dec_ReadReg1 == exe_WriteReg)) |
                        (dec_Uses2 & (dec_ReadReg2 == exe_WriteReg)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN: begin
                if (w_dstall) begin
                    w_next = S_DWAIT;
                end else if (exe_BrTaken || w_loaduse) begin
                    w_next = S_RUN;
                end else if (dec_Halt) begin
                    w_next = S_HALTED;
                end
            end
            S_DWAIT: begin
                if (dmem_Done) begin
                    w_next = S_RUN;
                end
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_RUN;
        endcase
    end

    always_comb begin
        pc_Hold      = 1'b0;
        ifid_Hold    = 1'b0;
        idex_Hold    = 1'b0;
        exmem_Hold   = 1'b0;
        ifid_Flush   = 1'b0;
        idex_Bubble  = 1'b0;
        memwb_Bubble = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (w_dstall) begin
                        pc_Hold      = 1'b1;
                        ifid_Hold    = 1'b1;
                        idex_Hold    = 1'b1;
                        exmem_Hold   = 1'b1;
                        memwb_Bubble = 1'b1;
                    end else if (exe_BrTaken) begin
                        ifid_Flush  = 1'b1;
                        idex_Bubble = 1'b1;
                    end else if (w_loaduse) begin
                        pc_Hold     = 1'b1;
                        ifid_Hold   = 1'b1;
                        idex_Bubble = 1'b1;
                    end else if (dec_Halt) begin
                        pc_Hold   = 1'b1;
                        ifid_Hold = 1'b1;
                    end
                end
                S_DWAIT: begin
                    if (!dmem_Done) begin
                        pc_Hold      = 1'b1;
                        ifid_Hold    = 1'b1;
                        idex_Hold    = 1'b1;
                        exmem_Hold   = 1'b1;
                        memwb_Bubble = 1'b1;
                    end
                end
                S_HALTED: begin
                    pc_Hold     = 1'b1;
                    ifid_Hold   = 1'b1;
                    idex_Bubble = 1'b1;
                    halted      = 1'b1;
                    // An older load/store still in MEM must finish before draining continues.
                    if (w_dstall) begin
                        idex_Hold    = 1'b1;
                        exmem_Hold   = 1'b1;
                        memwb_Bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (pc_Hold && (r_state != S_HALTED) && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: driver queues expected controls, negedge monitor compares.
module tb_pipe_stall_ctrl;
    localparam int CW = 4;

    localparam logic [7:0] PC = 8'h80, IFID = 8'h40, IDEX = 8'h20, EXMEM = 8'h10;
    localparam logic [7:0] FL = 8'h08, IB = 8'h04, MB = 8'h02, HL = 8'h01;
    localparam logic [7:0] DS = PC | IFID | IDEX | EXMEM | MB;
    localparam logic [7:0] LU = PC | IFID | IB;
    localparam logic [7:0] BR = FL | IB;
    localparam logic [7:0] HR = PC | IFID;
    localparam logic [7:0] HO = PC | IFID | IB | HL;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] dec_ReadReg1, dec_ReadReg2, exe_WriteReg;
    logic dec_Uses1, dec_Uses2, dec_Halt;
    logic exe_RegWrite, exe_DMemRead, exe_BrTaken;
    logic mem_DMemEn, dmem_Stall, dmem_Done;
    logic pc_Hold, ifid_Hold, idex_Hold, exmem_Hold;
    logic ifid_Flush, idex_Bubble, memwb_Bubble, halted;
`ifdef PIPE_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    pipe_stall_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_ReadReg1(dec_ReadReg1), .dec_ReadReg2(dec_ReadReg2),
        .dec_Uses1(dec_Uses1), .dec_Uses2(dec_Uses2), .dec_Halt(dec_Halt),
        .exe_WriteReg(exe_WriteReg), .exe_RegWrite(exe_RegWrite),
        .exe_DMemRead(exe_DMemRead), .exe_BrTaken(exe_BrTaken),
        .mem_DMemEn(mem_DMemEn), .dmem_Stall(dmem_Stall), .dmem_Done(dmem_Done),
        .pc_Hold(pc_Hold), .ifid_Hold(ifid_Hold), .idex_Hold(idex_Hold),
        .exmem_Hold(exmem_Hold), .ifid_Flush(ifid_Flush), .idex_Bubble(idex_Bubble),
        .memwb_Bubble(memwb_Bubble), .halted(halted)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [7:0]    o;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_cnt = '0;

    initial begin : monitor
        exp_t it;
        logic [7:0] obs;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it  = q.pop_front();
                obs = {pc_Hold, ifid_Hold, idex_Hold, exmem_Hold,
                       ifid_Flush, idex_Bubble, memwb_Bubble, halted};
                checks++;
                if (obs !== it.o) begin
                    errors++;
                    $display("FAIL %s ctrl: got %b expected %b", it.nm, obs, it.o);
                end
`ifdef PIPE_STALL_CNT_EN
                checks++;
                if (stall_cnt !== it.cnt) begin
                    errors++;
                    $display("FAIL %s stall_cnt: got %0d expected %0d", it.nm, stall_cnt, it.cnt);
                end
`endif
            end
        end
    end

    task automatic clr();
        rst = 1'b0;
        dec_ReadReg1 = 3'd0; dec_ReadReg2 = 3'd0; exe_WriteReg = 3'd0;
        dec_Uses1 = 1'b0; dec_Uses2 = 1'b0; dec_Halt = 1'b0;
        exe_RegWrite = 1'b0; exe_DMemRead = 1'b0; exe_BrTaken = 1'b0;
        mem_DMemEn = 1'b0; dmem_Stall = 1'b0; dmem_Done = 1'b0;
    endtask

    task automatic set_loaduse();
        exe_DMemRead = 1'b1; exe_RegWrite = 1'b1; exe_WriteReg = 3'd3;
        dec_Uses2 = 1'b1; dec_ReadReg2 = 3'd3;
    endtask

    task automatic set_dstall();
        mem_DMemEn = 1'b1; dmem_Stall = 1'b1;
    endtask

    // Queue expectation for this cycle, then advance the counter model past the edge.
    task automatic step(input string nm, input logic [7:0] e);
        exp_t it;
        it.nm = nm; it.o = e; it.cnt = exp_cnt;
        q.push_back(it);
        if (rst) exp_cnt = '0;
        else if (e[7] && !e[0] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = '0;

        dec_Halt = 1'b1; exe_BrTaken = 1'b1; set_dstall();
        step("reset_quiet", 8'h00);
        clr(); step("idle", 8'h00);

        set_dstall();
        step("dw1", DS);
        exe_BrTaken = 1'b1;
        step("dw2_br", DS);
        step("dw3_br", DS);
        dmem_Done = 1'b1;
        step("dw_done", 8'h00);
        clr(); exe_BrTaken = 1'b1;
        step("br_after_dw", BR);

        clr(); set_dstall(); dmem_Done = 1'b1;
        step("done_wins", 8'h00);

        clr(); set_loaduse();
        step("loaduse", LU);
        exe_DMemRead = 1'b0;
        step("lu_cleared", 8'h00);
        set_loaduse(); dec_Uses2 = 1'b0;
        step("lu_nouse", 8'h00);
        dec_Uses1 = 1'b1; dec_ReadReg1 = 3'd3;
        step("lu_r1", LU);
        clr(); set_loaduse(); exe_RegWrite = 1'b0;
        step("lu_norw", 8'h00);
        clr(); set_loaduse(); dec_ReadReg2 = 3'd4;
        step("lu_regdiff", 8'h00);
        clr(); set_loaduse(); exe_BrTaken = 1'b1;
        step("br_lu", BR);

        clr(); set_loaduse(); dec_Halt = 1'b1;
        step("lu_over_halt", LU);
        clr();
        step("not_halted", 8'h00);

        dec_Halt = 1'b1;
        step("halt_run", HR);
        clr();
        step("halted1", HO);
        exe_BrTaken = 1'b1; set_loaduse();
        step("halted_br", HO);
        clr(); set_dstall();
        step("halted_dm", HO | IDEX | EXMEM | MB);
        clr();
        step("halted2", HO);
        rst = 1'b1;
        step("rst_halted", 8'h00);
        clr();
        step("run_after_rst", 8'h00);

        set_dstall();
        step("dw_in", DS);
        rst = 1'b1;
        step("rst_dwait", 8'h00);
        clr();
        step("dw_abandon", 8'h00);

        set_dstall();
        for (int i = 0; i < 20; i++) step("sat_hold", DS);
        dmem_Done = 1'b1;
        step("sat_done", 8'h00);
        clr();
        step("sat_cnt", 8'h00);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
